// File: rtl/m_main.sv
//------------------------------------------------------------------------------
// Module      : m_main
// Description : Bit-serial 32-bit ADD/SUB/AND/OR/XOR datapath, one bit per
//               clock, LSB first, through a 1-bit adder/logic slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_main #(
    parameter logic [31:0] OPA = 32'd6,
    parameter logic [31:0] OPB = 32'd7,
    parameter logic [2:0]  OP  = 3'd0
) (
    input  logic        w_clk,
    input  logic        w_rst,
    output logic [31:0] w_rslt
);

    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_or  = 3'd3;
    localparam logic [2:0] c_op_xor = 3'd4;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state, w_state_d;
    logic [31:0] r_rrs, w_rrs_d;
    logic [31:0] r_rrt, w_rrt_d;
    logic [31:0] r_shiftrega, w_shiftrega_d;
    logic [31:0] r_shiftregb, w_shiftregb_d;
    logic        r_carry, w_carry_d;
    logic [5:0]  r_cnt, w_cnt_d;
    logic [31:0] r_rslt, w_rslt_d;

    logic w_is_sub;
    logic w_a;
    logic w_b;
    logic w_sum;
    logic w_cout;

    assign w_is_sub = (OP == c_op_sub);
    assign w_a      = r_shiftrega[0];
    assign w_b      = r_shiftregb[0];

    // One-bit slice: logic ops kill the carry; codes 5-7 fall through to ADD.
    always_comb begin
        w_sum  = w_a ^ w_b ^ r_carry;
        w_cout = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
        case (OP)
            c_op_and: begin w_sum = w_a & w_b; w_cout = 1'b0; end
            c_op_or:  begin w_sum = w_a | w_b; w_cout = 1'b0; end
            c_op_xor: begin w_sum = w_a ^ w_b; w_cout = 1'b0; end
            default:  ;
        endcase
    end

    always_comb begin
        w_state_d     = r_state;
        w_rrs_d       = r_rrs;
        w_rrt_d       = r_rrt;
        w_shiftrega_d = r_shiftrega;
        w_shiftregb_d = r_shiftregb;
        w_carry_d     = r_carry;
        w_cnt_d       = r_cnt;
        w_rslt_d      = r_rslt;
        case (r_state)
            S_LOAD: begin
                w_shiftrega_d = r_rrs;
                w_shiftregb_d = w_is_sub ? ~r_rrt : r_rrt;
                w_carry_d     = w_is_sub;
                w_cnt_d       = 6'd0;
                w_state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (!r_cnt[5]) begin
                    w_shiftrega_d = {w_sum, r_shiftrega[31:1]};
                    w_shiftregb_d = {1'b0, r_shiftregb[31:1]};
                    w_carry_d     = w_cout;
                    w_cnt_d       = r_cnt + 6'd1;
                end else begin
                    w_rslt_d  = r_shiftrega;
                    w_state_d = S_DONE;
                end
            end
            S_DONE: ;
            default: w_state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_state     <= S_LOAD;
            r_rrs       <= OPA;
            r_rrt       <= OPB;
            r_shiftrega <= 32'd0;
            r_shiftregb <= 32'd0;
            r_carry     <= 1'b0;
            r_cnt       <= 6'd0;
            r_rslt      <= 32'd0;
        end else begin
            r_state     <= w_state_d;
            r_rrs       <= w_rrs_d;
            r_rrt       <= w_rrt_d;
            r_shiftrega <= w_shiftrega_d;
            r_shiftregb <= w_shiftregb_d;
            r_carry     <= w_carry_d;
            r_cnt       <= w_cnt_d;
            r_rslt      <= w_rslt_d;
        end
    end

    assign w_rslt = r_rslt;

endmodule

`default_nettype wire

// File: tb/tb_m_main.sv
//------------------------------------------------------------------------------
// Module      : tb_m_main
// Description : Self-checking bench for m_main across several operand/op sets.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_m_main;

    localparam int N = 8;
    localparam logic [31:0] c_opa [N] = '{32'd6, 32'hFFFF_FFFF, 32'd5, 32'd7,
                                         32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'h1234_5678};
    localparam logic [31:0] c_opb [N] = '{32'd7, 32'd1, 32'd7, 32'd5,
                                         32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h8765_4321};
    localparam logic [2:0]  c_op  [N] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

    logic        w_clk;
    logic        w_rst;
    logic [31:0] w_rslt [N];

    int checks = 0;
    int errors = 0;

    m_main #(.OPA(c_opa[0]), .OPB(c_opb[0]), .OP(c_op[0])) u_dut  (.w_clk(w_clk), .w_rst(w_rst), .w_rslt(w_rslt[0]));
    m_main #(.OPA(c_opa[1]), .OPB(c_opb[1]), .OP(c_op[1])) u_wrap (.w_clk(w_clk), .w_rst(w_rst), .w_rslt(w_rslt[1]));
    m_main #(.OPA(c_opa[2]), .OPB(c_opb[2]), .OP(c_op[2])) u_sub1 (.w_clk(w_clk), .w_rst(w_rst), .w_rslt(w_rslt[2]));
    m_main #(.OPA(c_opa[3]), .OPB(c_opb[3]), .OP(c_op[3])) u_sub2 (.w_clk(w_clk), .w_rst(w_rst), .w_rslt(w_rslt[3]));
    m_main #(.OPA(c_opa[4]), .OPB(c_opb[4]), .OP(c_op[4])) u_and  (.w_clk(w_clk), .w_rst(w_rst), .w_rslt(w_rslt[4]));
    m_main #(.OPA(c_opa[5]), .OPB(c_opb[5]), .OP(c_op[5])) u_or   (.w_clk(w_clk), .w_rst(w_rst), .w_rslt(w_rslt[5]));
    m_main #(.OPA(c_opa[6]), .OPB(c_opb[6]), .OP(c_op[6])) u_xor  (.w_clk(w_clk), .w_rst(w_rst), .w_rslt(w_rslt[6]));
    m_main #(.OPA(c_opa[7]), .OPB(c_opb[7]), .OP(c_op[7])) u_op7  (.w_clk(w_clk), .w_rst(w_rst), .w_rslt(w_rslt[7]));

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Reference: the whole-word result of the operation, modulo 2^32.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Counter value expected after edge e following reset release.
    function automatic logic [31:0] cnt_model(input int e);
        if (e <= 1) return 32'd0;
        return (e - 1 > 32) ? 32'd32 : 32'(e - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_inst%0d", tag, i), w_rslt[i], model(c_opa[i], c_opb[i], c_op[i]));
    endtask

    // Run n edges after release, checking counter progress and result latency.
    task automatic run_edges(input int n, input string tag);
        for (int e = 1; e <= n; e++) begin
            @(posedge w_clk);
            #1;
            if (e <= 40)
                check($sformatf("%s_cnt_e%0d", tag, e), {26'd0, u_dut.r_cnt}, cnt_model(e));
            if (e <= 33)
                check($sformatf("%s_zero_e%0d", tag, e), w_rslt[0], 32'd0);
            else if (e == 34)
                check_all($sformatf("%s_e34", tag));
            else
                check($sformatf("%s_hold_e%0d", tag, e), w_rslt[0], 32'd13);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rslt"}, w_rslt[0], 32'd0);
        check({tag, "_cnt"}, {26'd0, u_dut.r_cnt}, 32'd0);
        check({tag, "_sra"}, u_dut.r_shiftrega, 32'd0);
        check({tag, "_srb"}, u_dut.r_shiftregb, 32'd0);
        check({tag, "_carry"}, {31'd0, u_dut.r_carry}, 32'd0);
        check({tag, "_rrs"}, u_dut.r_rrs, 32'd6);
        check({tag, "_rrt"}, u_dut.r_rrt, 32'd7);
    endtask

    initial begin
        int k;
        w_rst = 1'b0;
        repeat (3) @(posedge w_clk);
        @(negedge w_clk);
        check_reset_state("por");

        // Full run with long hold window.
        w_rst = 1'b1;
        run_edges(200, "run");
        check("rrs_kept", u_dut.r_rrs, 32'd6);
        check("rrt_kept", u_dut.r_rrt, 32'd7);
        check_all("final");

        // Directed mid-shift abort at cycle 15, held for two cycles.
        @(negedge w_clk);
        w_rst = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b1;
        run_edges(15, "pre_abort");
        #2;
        w_rst = 1'b0;
        #1;
        check_reset_state("abort");
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        w_rst = 1'b1;
        run_edges(40, "after_abort");

        // Random abort points, including some after completion.
        for (int t = 0; t < 8; t++) begin
            k = int'($urandom_range(1, 45));
            @(negedge w_clk);
            w_rst = 1'b0;
            @(negedge w_clk);
            w_rst = 1'b1;
            run_edges(k, $sformatf("rnd%0d_pre", t));
            #2;
            w_rst = 1'b0;
            #1;
            check($sformatf("rnd%0d_abort_cnt", t), {26'd0, u_dut.r_cnt}, 32'd0);
            check($sformatf("rnd%0d_abort_rslt", t), w_rslt[0], 32'd0);
            @(negedge w_clk);
            w_rst = 1'b1;
            run_edges(36, $sformatf("rnd%0d_post", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
